aes_result_buffer: RTL and testbench
====================================

# aes_result_buffer

Output-side collector that sits directly downstream of the AES last-round stage. Each cycle it samples the final-round result and its registered job tag. It stores only valid jobs (ENCRYPT/DECRYPT) in an in-order FIFO and hands them to the host through a valid/ready port. The round pipeline cannot stall, so the block also exports an almost-full credit signal for the job issuer, and it records any result lost to overflow.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- AFULL_MARGIN, 4, free slots reserved for jobs already in flight in the round pipeline; 1 ≤ AFULL_MARGIN < DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  128  last-round result, aligned with in_type.
- in_type  in  job_t  job tag from last round (INVALID, ENCRYPT, DECRYPT).
- clear  in  1  synchronous flush; empties FIFO, clears status.
- res_data  out  128  head-entry result.
- res_type  out  job_t  head-entry job tag.
- res_valid  out  1  head entry present.
- res_ready  in  1  host accepts head entry.
- count  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
- almost_full  out  1  count ≥ DEPTH − AFULL_MARGIN.
- overflow  out  1  sticky; set when a valid result is dropped.
- drop_cnt  out  8  dropped results; saturates at 255.

## Operation
- push = (in_type != INVALID); pop = res_valid && res_ready.
- Each entry stores {in_data, in_type}. Write at wr_ptr, read at rd_ptr. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Push when count < DEPTH: write the entry and increment wr_ptr.
- Push when count == DEPTH, no pop: drop the entry. wr_ptr is unchanged, overflow ← 1, drop_cnt ← min(drop_cnt+1, 255).
- Push and pop when count == DEPTH: the push is accepted. count stays DEPTH. No drop.
- Push and pop when 0 < count < DEPTH: both are performed. count unchanged.
- Pop when count == 0: impossible, because res_valid = 0.
- No bypass: a push into an empty FIFO becomes visible on the next cycle.
- res_valid = (count != 0). res_data/res_type = mem[rd_ptr] when count != 0, otherwise 128'h0 / INVALID.
- res_data and res_type are held stable while res_valid && !res_ready.
- clear has priority over everything:
  - count, wr_ptr, rd_ptr, overflow and drop_cnt ← 0.
  - Any push or pop in the same cycle is ignored.
  - Stored data need not be zeroed.
- INVALID tags never occupy storage or affect any counter.
- Reset values: res_data 0, res_type INVALID, res_valid 0, count 0, almost_full 0, overflow 0, drop_cnt 0, pointers 0.
- Reset mid-operation: all stored entries are discarded and outputs return to reset values asynchronously.

## Timing
- Latency: in_type/in_data sampled at edge N appear on res_* after edge N when the FIFO was empty. res_valid rises in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- count, almost_full, overflow and drop_cnt are registered and update on the same edge as the push/pop/drop that changes them.
- almost_full is a combinational decode of registered count.
- The issuer must stop issuing while almost_full = 1. AFULL_MARGIN covers jobs already launched.
- Ordering: results leave strictly in arrival order; ENCRYPT and DECRYPT are not reordered.

## Test plan
- Single push: ENCRYPT with in_data 128'h3925841d02dc09fbdc118597196a0b32 while empty -> next cycle res_valid = 1, matching data/tag, count = 1. Pop with res_ready = 1 -> count 0, res_type INVALID.
- Mixed tags: sequence ENCRYPT, INVALID, DECRYPT, INVALID, ENCRYPT with distinct data, res_ready = 0 -> count = 3. Draining returns the 3 entries in order. INVALID never appears.
- Fill/overflow (DEPTH 8, AFULL_MARGIN 4): 8 pushes, res_ready = 0 -> almost_full asserts after the 4th push, count = 8. 9th and 10th pushes -> overflow = 1, drop_cnt = 2. Drain returns the first 8 intact.
- Full with simultaneous push+pop: count = 8, push and pop in one cycle -> count stays 8, no drop, new entry lands last. Pointers wrap cleanly over 20 such cycles.
- Saturation and clear: 300 forced drops -> drop_cnt = 255. Assert clear with a simultaneous push -> count 0, overflow 0, drop_cnt 0, res_valid 0 next cycle.
- Backpressure and async reset: res_ready toggled randomly -> res_* stable while stalled. Assert rst_n low mid-stream -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/aes_result_buffer.sv
// Result collector behind the AES last-round stage: in-order FIFO of valid jobs,
// valid/ready host port, almost-full credit for the issuer and overflow accounting.

package aes_result_buffer_pkg;
   typedef enum logic [1:0] {
      INVALID = 2'd0,
      ENCRYPT = 2'd1,
      DECRYPT = 2'd2
   } job_t;
endpackage

module aes_result_buffer
   import aes_result_buffer_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [127:0]               in_data,
   input  job_t                       in_type,
   input  logic                       clear,
   output logic [127:0]               res_data,
   output job_t                       res_type,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [127:0]  data_mem [DEPTH];
   job_t          type_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic          push;
   logic          pop;
   logic          full;
   logic          accept;
   logic          drop;

   // The round pipeline cannot stall, so a push into a full FIFO only lands
   // if the host frees the head slot in the same cycle.
   always_comb begin
      push   = (in_type != INVALID);
      pop    = res_valid && res_ready;
      full   = (count == CW'(DEPTH));
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   always_comb begin
      res_valid   = (count != '0);
      almost_full = (count >= CW'(DEPTH - AFULL_MARGIN));
      res_data    = '0;
      res_type    = INVALID;
      if (res_valid) begin
         res_data = data_mem[rd_ptr];
         res_type = type_mem[rd_ptr];
      end
   end

   // Storage carries no reset; an empty count masks whatever the slots hold.
   always_ff @(posedge clk) begin
      if (accept && !clear) begin
         data_mem[wr_ptr] <= in_data;
         type_mem[wr_ptr] <= in_type;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (accept && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !accept) begin
            count <= count - CW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_result_buffer.sv
// Directed self-checking bench for aes_result_buffer with an in-order
// reference queue for the head entry and status outputs.

module tb_aes_result_buffer;
   import aes_result_buffer_pkg::*;

   localparam int DEPTH        = 8;
   localparam int AFULL_MARGIN = 4;

   logic          clk;
   logic          rst_n;
   logic [127:0]  in_data;
   job_t          in_type;
   logic          clear;
   logic [127:0]  res_data;
   job_t          res_type;
   logic          res_valid;
   logic          res_ready;
   logic [3:0]    count;
   logic          almost_full;
   logic          overflow;
   logic [7:0]    drop_cnt;

   typedef struct {
      logic [127:0] d;
      job_t         t;
   } entry_t;

   entry_t        q[$];
   logic          exp_ovf;
   int            exp_drop;
   int            checks;
   int            errors;
   logic [127:0]  prev_data;
   job_t          prev_type;
   logic          prev_stall;

   aes_result_buffer #(
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (AFULL_MARGIN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_type     (in_type),
      .clear       (clear),
      .res_data    (res_data),
      .res_type    (res_type),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of stimulus, advances the reference queue, and returns #1 after the edge.
   task automatic apply_stimulus(input job_t t, input logic [127:0] d, input logic rdy, input logic clr);
      logic pop_e;
      logic full_e;
      in_type   = t;
      in_data   = d;
      res_ready = rdy;
      clear     = clr;
      if (clr) begin
         q.delete();
         exp_ovf  = 1'b0;
         exp_drop = 0;
      end else begin
         pop_e  = (q.size() != 0) && rdy;
         full_e = (q.size() == DEPTH);
         if (pop_e) void'(q.pop_front());
         if (t != INVALID) begin
            if (!full_e || pop_e) begin
               q.push_back('{d: d, t: t});
            end else begin
               exp_ovf = 1'b1;
               if (exp_drop < 255) exp_drop++;
            end
         end
      end
      @(posedge clk);
      #1;
      in_type = INVALID;
      in_data = '0;
      clear   = 1'b0;
   endtask

   task automatic check_state(input string tag);
      if (q.size() != 0) begin
         check_output({tag, ".valid"}, 128'(res_valid), 128'(1'b1));
         check_output({tag, ".data"},  res_data, q[0].d);
         check_output({tag, ".type"},  128'(res_type), 128'(q[0].t));
      end else begin
         check_output({tag, ".valid"}, 128'(res_valid), 128'(1'b0));
         check_output({tag, ".data"},  res_data, 128'h0);
         check_output({tag, ".type"},  128'(res_type), 128'(INVALID));
      end
      check_output({tag, ".count"}, 128'(count), 128'(q.size()));
      check_output({tag, ".afull"}, 128'(almost_full), 128'(q.size() >= DEPTH - AFULL_MARGIN));
      check_output({tag, ".ovf"},   128'(overflow), 128'(exp_ovf));
      check_output({tag, ".drops"}, 128'(drop_cnt), 128'(exp_drop));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      exp_ovf   = 1'b0;
      exp_drop  = 0;
      rst_n     = 1'b0;
      in_data   = '0;
      in_type   = INVALID;
      clear     = 1'b0;
      res_ready = 1'b0;

      #12;
      check_output("rst.valid", 128'(res_valid), 128'h0);
      check_output("rst.data",  res_data, 128'h0);
      check_output("rst.type",  128'(res_type), 128'(INVALID));
      check_output("rst.count", 128'(count), 128'h0);
      check_output("rst.afull", 128'(almost_full), 128'h0);
      check_output("rst.ovf",   128'(overflow), 128'h0);
      check_output("rst.drops", 128'(drop_cnt), 128'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single push");
      apply_stimulus(ENCRYPT, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0);
      check_output("single.valid", 128'(res_valid), 128'h1);
      check_output("single.data",  res_data, 128'h3925841d02dc09fbdc118597196a0b32);
      check_output("single.type",  128'(res_type), 128'(ENCRYPT));
      check_output("single.count", 128'(count), 128'h1);
      apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
      check_output("single.pop.count", 128'(count), 128'h0);
      check_output("single.pop.type",  128'(res_type), 128'(INVALID));
      check_output("single.pop.valid", 128'(res_valid), 128'h0);

      $display("[TB] mixed tags");
      apply_stimulus(ENCRYPT, 128'hA1, 1'b0, 1'b0);
      apply_stimulus(INVALID, 128'hFF01, 1'b0, 1'b0);
      apply_stimulus(DECRYPT, 128'hA2, 1'b0, 1'b0);
      apply_stimulus(INVALID, 128'hFF02, 1'b0, 1'b0);
      apply_stimulus(ENCRYPT, 128'hA3, 1'b0, 1'b0);
      check_output("mixed.count", 128'(count), 128'h3);
      res_ready = 1'b1;
      #1;
      check_output("mixed.head0.data", res_data, 128'hA1);
      check_output("mixed.head0.type", 128'(res_type), 128'(ENCRYPT));
      apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
      check_output("mixed.head1.data", res_data, 128'hA2);
      check_output("mixed.head1.type", 128'(res_type), 128'(DECRYPT));
      apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
      check_output("mixed.head2.data", res_data, 128'hA3);
      check_output("mixed.head2.type", 128'(res_type), 128'(ENCRYPT));
      apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
      check_output("mixed.empty.count", 128'(count), 128'h0);

      $display("[TB] fill and overflow");
      for (int k = 0; k < DEPTH; k++) begin
         apply_stimulus(k[0] ? DECRYPT : ENCRYPT, 128'h1000 + 128'(k), 1'b0, 1'b0);
         check_output("fill.count", 128'(count), 128'(k + 1));
         check_output("fill.afull", 128'(almost_full), 128'(k + 1 >= 4));
      end
      apply_stimulus(ENCRYPT, 128'hDEAD1, 1'b0, 1'b0);
      apply_stimulus(DECRYPT, 128'hDEAD2, 1'b0, 1'b0);
      check_output("ovf.flag",  128'(overflow), 128'h1);
      check_output("ovf.drops", 128'(drop_cnt), 128'h2);
      check_output("ovf.count", 128'(count), 128'h8);
      res_ready = 1'b1;
      #1;
      for (int k = 0; k < DEPTH; k++) begin
         check_output("drain.data", res_data, 128'h1000 + 128'(k));
         check_output("drain.type", 128'(res_type), 128'(k[0] ? DECRYPT : ENCRYPT));
         apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
      end
      check_state("drain.end");

      $display("[TB] full with push and pop");
      for (int k = 0; k < DEPTH; k++) begin
         apply_stimulus(ENCRYPT, 128'h2000 + 128'(k), 1'b0, 1'b0);
      end
      for (int j = 0; j < 20; j++) begin
         apply_stimulus(j[0] ? ENCRYPT : DECRYPT, 128'h3000 + 128'(j), 1'b1, 1'b0);
         check_output("pp.count", 128'(count), 128'h8);
         check_output("pp.drops", 128'(drop_cnt), 128'h2);
         check_state("pp");
      end
      check_output("pp.head", res_data, 128'h3000 + 128'd12);
      for (int k = 0; k < DEPTH; k++) begin
         apply_stimulus(INVALID, 128'h0, 1'b1, 1'b0);
         check_state("pp.drain");
      end

      $display("[TB] saturation and clear");
      apply_stimulus(INVALID, 128'h0, 1'b0, 1'b1);
      check_state("clr1");
      for (int k = 0; k < DEPTH; k++) begin
         apply_stimulus(DECRYPT, 128'h4000 + 128'(k), 1'b0, 1'b0);
      end
      for (int k = 0; k < 300; k++) begin
         apply_stimulus(ENCRYPT, 128'h5000 + 128'(k), 1'b0, 1'b0);
      end
      check_output("sat.drops", 128'(drop_cnt), 128'd255);
      check_output("sat.ovf",   128'(overflow), 128'h1);
      check_output("sat.head",  res_data, 128'h4000);
      apply_stimulus(ENCRYPT, 128'h6666, 1'b1, 1'b1);
      check_output("clr2.count", 128'(count), 128'h0);
      check_output("clr2.ovf",   128'(overflow), 128'h0);
      check_output("clr2.drops", 128'(drop_cnt), 128'h0);
      check_output("clr2.valid", 128'(res_valid), 128'h0);

      $display("[TB] backpressure");
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_type  = INVALID;
      for (int k = 0; k < 80; k++) begin
         logic rdy;
         job_t t;
         rdy = 1'($urandom_range(0, 1));
         t   = job_t'(2'($urandom_range(0, 2)));
         prev_stall = res_valid && !rdy;
         prev_data  = res_data;
         prev_type  = res_type;
         apply_stimulus(t, {$urandom, $urandom, $urandom, $urandom}, rdy, 1'b0);
         if (prev_stall) begin
            check_output("stall.data", res_data, prev_data);
            check_output("stall.type", 128'(res_type), 128'(prev_type));
         end
         check_state("bp");
      end

      $display("[TB] async reset");
      for (int k = 0; k < DEPTH + 3; k++) begin
         apply_stimulus(ENCRYPT, 128'h7000 + 128'(k), 1'b0, 1'b0);
      end
      check_output("pre_rst.ovf", 128'(overflow), 128'h1);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_ovf  = 1'b0;
      exp_drop = 0;
      check_output("arst.valid", 128'(res_valid), 128'h0);
      check_output("arst.data",  res_data, 128'h0);
      check_output("arst.type",  128'(res_type), 128'(INVALID));
      check_output("arst.count", 128'(count), 128'h0);
      check_output("arst.afull", 128'(almost_full), 128'h0);
      check_output("arst.ovf",   128'(overflow), 128'h0);
      check_output("arst.drops", 128'(drop_cnt), 128'h0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply_stimulus(DECRYPT, 128'h8888, 1'b0, 1'b0);
      check_state("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
